// File: rtl/register_file_mp_pkg.sv
// Shared definitions for the multi-port register file: address-width helper,
// architectural register indices and the write-port transaction type.
package regfile_pkg;

  localparam int REG_SP = 13;
  localparam int REG_LR = 14;
  localparam int REG_PC = 15;

  localparam int RF_DATA_W_DEF = 32;
  localparam int RF_ADDR_W_DEF = 4;

  // Smallest width able to index n registers, never below 1 bit.
  function automatic int addr_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  typedef struct packed {
    logic                     we;
    logic [RF_ADDR_W_DEF-1:0] addr;
    logic [RF_DATA_W_DEF-1:0] data;
  } regfile_wr_t;

endpackage

// File: rtl/register_file_mp_if.sv
// Bus between the pipeline and the register file: three read ports, two write
// ports, load scoreboard marking and the debug LED tap.
interface register_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int LED_W  = 4
);
  logic [ADDR_W-1:0] A1;
  logic [ADDR_W-1:0] A2;
  logic [ADDR_W-1:0] A3R;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic [DATA_W-1:0] RD3;
  logic              busy1;
  logic              busy2;
  logic              busy3;
  logic              we0;
  logic [ADDR_W-1:0] wa0;
  logic [DATA_W-1:0] wd0;
  logic              we1;
  logic [ADDR_W-1:0] wa1;
  logic [DATA_W-1:0] wd1;
  logic              mark;
  logic [ADDR_W-1:0] mark_a;
  logic              any_busy;
  logic [LED_W-1:0]  led;

  modport master (
    output A1, A2, A3R, we0, wa0, wd0, we1, wa1, wd1, mark, mark_a,
    input  RD1, RD2, RD3, busy1, busy2, busy3, any_busy, led
  );

  modport slave (
    input  A1, A2, A3R, we0, wa0, wd0, we1, wa1, wd1, mark, mark_a,
    output RD1, RD2, RD3, busy1, busy2, busy3, any_busy, led
  );
endinterface

// File: rtl/register_file_mp_scoreboard.sv
// Busy bit per register for outstanding loads: set when a load issues,
// cleared by the load writeback port.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = addr_width(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              mark,
  input  logic [ADDR_W-1:0] mark_a,
  input  logic              clr,
  input  logic [ADDR_W-1:0] clr_a,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  output logic              busy1,
  output logic              busy2,
  output logic              busy3,
  output logic              any_busy
);

  logic [NUM_REGS-1:0] busy;

  // A new load marking the register its predecessor is completing keeps it busy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      if (clr)  busy[clr_a]  <= 1'b0;
      if (mark) busy[mark_a] <= 1'b1;
    end
  end

  assign busy1    = busy[a1];
  assign busy2    = busy[a2];
  assign busy3    = busy[a3];
  assign any_busy = |busy;

endmodule

// File: rtl/register_file_mp.sv
// Dual-write, triple-read register file with optional same-cycle bypass,
// load busy scoreboard and a debug LED tap of one register.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              NUM_REGS = 16,
  parameter int              ADDR_W   = addr_width(NUM_REGS),
  parameter int              BYPASS   = 1,
  parameter int              INIT_REG = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(2),
  parameter int              LED_REG  = 4,
  parameter int              LED_W    = 4
) (
  input logic clock,
  input logic reset_n,
  register_file_mp_if.slave rf
);

  if (!is_pow2(NUM_REGS) || NUM_REGS < 2) begin : g_chk_num
    $error("register_file_mp: NUM_REGS must be a power of two >= 2");
  end
  if (LED_REG >= NUM_REGS) begin : g_chk_led
    $error("register_file_mp: LED_REG out of range");
  end
  if (INIT_REG >= NUM_REGS) begin : g_chk_init
    $error("register_file_mp: INIT_REG out of range");
  end
  if (LED_W > DATA_W) begin : g_chk_ledw
    $error("register_file_mp: LED_W wider than DATA_W");
  end

  logic [DATA_W-1:0] regs [NUM_REGS];

  // W1 is written first so a same-address W0 write overrides it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == INIT_REG) ? INIT_VAL : '0;
      end
    end else begin
      if (rf.we1) regs[rf.wa1] <= rf.wd1;
      if (rf.we0) regs[rf.wa0] <= rf.wd0;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              we0,
    input logic [ADDR_W-1:0] wa0,
    input logic [DATA_W-1:0] wd0,
    input logic              we1,
    input logic [ADDR_W-1:0] wa1,
    input logic [DATA_W-1:0] wd1
  );
    logic [DATA_W-1:0] v;
    v = stored;
    if (BYPASS != 0) begin
      if (we0 && wa0 == a)      v = wd0;
      else if (we1 && wa1 == a) v = wd1;
    end
    return v;
  endfunction

  always_comb begin
    rf.RD1 = read_port(rf.A1, regs[rf.A1], rf.we0, rf.wa0, rf.wd0,
                       rf.we1, rf.wa1, rf.wd1);
    rf.RD2 = read_port(rf.A2, regs[rf.A2], rf.we0, rf.wa0, rf.wd0,
                       rf.we1, rf.wa1, rf.wd1);
    rf.RD3 = read_port(rf.A3R, regs[rf.A3R], rf.we0, rf.wa0, rf.wd0,
                       rf.we1, rf.wa1, rf.wd1);
  end

  assign rf.led = regs[LED_REG][LED_W-1:0];

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clock    (clock),
    .reset_n  (reset_n),
    .mark     (rf.mark),
    .mark_a   (rf.mark_a),
    .clr      (rf.we1),
    .clr_a    (rf.wa1),
    .a1       (rf.A1),
    .a2       (rf.A2),
    .a3       (rf.A3R),
    .busy1    (rf.busy1),
    .busy2    (rf.busy2),
    .busy3    (rf.busy3),
    .any_busy (rf.any_busy)
  );

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised successor to the processor's single-write register file.
- Three asynchronous read ports (Rn, Rm, Rs/Rd-store) and two clocked write ports: W0 for ALU writeback, W1 for load writeback.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard for outstanding loads, feeding the hazard unit; debug LED tap of one register.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 16, number of architectural registers (power of two, >= 2).
- ADDR_W, $clog2(NUM_REGS), register address width.
- BYPASS, 1, 1 = read ports return same-cycle write data; 0 = read ports return stored value only.
- INIT_REG, 4, index of the register given a non-zero reset value.
- INIT_VAL, 2, reset value of register INIT_REG.
- LED_REG, 4, index of the register driven onto led.
- LED_W, 4, led width (<= DATA_W).

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- A1  input  ADDR_W  read port 1 address.
- A2  input  ADDR_W  read port 2 address.
- A3R  input  ADDR_W  read port 3 address.
- RD1  output  DATA_W  read port 1 data.
- RD2  output  DATA_W  read port 2 data.
- RD3  output  DATA_W  read port 3 data.
- busy1  output  1  scoreboard bit of register A1.
- busy2  output  1  scoreboard bit of register A2.
- busy3  output  1  scoreboard bit of register A3R.
- we0  input  1  write enable, port 0 (ALU).
- wa0  input  ADDR_W  write address, port 0.
- wd0  input  DATA_W  write data, port 0.
- we1  input  1  write enable, port 1 (load).
- wa1  input  ADDR_W  write address, port 1.
- wd1  input  DATA_W  write data, port 1.
- mark  input  1  set busy bit of register mark_a (load issued).
- mark_a  input  ADDR_W  register to mark busy.
- any_busy  output  1  OR of all busy bits.
- led  output  LED_W  registerFile[LED_REG][LED_W-1:0].

Behaviour:
- Reset: asserting reset_n low immediately clears all registers to 0, except register INIT_REG = INIT_VAL. All busy bits clear. Outputs follow combinationally: led = INIT_VAL[LED_W-1:0] when LED_REG == INIT_REG, any_busy = 0. Reset overrides any same-cycle write or mark. Deassertion is synchronised by the instantiating top.
- Write: on a rising clock edge with we0 and/or we1, the addressed register takes its data. Write latency is 1 cycle.
- Write collision: we0 and we1 to the same address in the same cycle -> W0 data is stored; W1 is dropped silently.
- Read: combinational from the array.
- Bypass (BYPASS = 1): if a write port is enabled to the read address this cycle, RDx returns that write data; W0 has priority over W1, matching storage.
- Bypass (BYPASS = 0): RDx shows the new value only from the cycle after the edge.
- Busy set: mark sets busy[mark_a] at the clock edge.
- Busy clear: we1 clears busy[wa1] at the clock edge. we0 does not clear busy; ALU writeback to a busy register leaves it busy.
- Simultaneous mark and we1 on the same address -> busy stays set (the new load wins). On different addresses, both actions occur.
- Busy bypass: busyX is the registered bit, with no bypass.
- No special register: register NUM_REGS-1 (PC) is an ordinary register here.
- Out-of-range addresses cannot occur (NUM_REGS is a power of two).
- Data width: values are stored and returned unmodified; no sign or width conversion.
- Static parameter checks: LED_REG < NUM_REGS; INIT_REG < NUM_REGS; LED_W <= DATA_W.

Decomposition:
- Shared package regfile_pkg: ADDR_W derivation function, register-index constants (REG_SP = 13, REG_LR = 14, REG_PC = 15), and a regfile_wr_t struct {we, addr, data}.
- One natural sub-module: regfile_scoreboard, holding the busy vector with mark/clear logic, the three busy lookups and any_busy.
- Storage, write priority and bypass muxes stay in the top module.

Test Plan:
- Reset: drive reset_n low mid-run after writing R1 = 0xDEAD0000 -> all RDx read 0, R4 reads 2, led = 4'h2, any_busy = 0; takes effect without a clock edge.
- Single write and bypass: we0, wa0 = 3, wd0 = 0x12345678, A1 = 3 -> with BYPASS = 1, RD1 = 0x12345678 in the same cycle; with BYPASS = 0, RD1 = 0 that cycle and 0x12345678 after the edge.
- Dual-write collision: we0 = we1 = 1, wa0 = wa1 = 5, wd0 = 0xAAAA, wd1 = 0xBBBB -> R5 = 0xAAAA after the edge and bypassed RD2 = 0xAAAA. Repeat with wa1 = 6 -> R5 = 0xAAAA, R6 = 0xBBBB.
- Scoreboard: mark, mark_a = 7 -> busy1 = 1 next cycle (A1 = 7), any_busy = 1. Then we0 to R7 -> still busy. Then we1, wa1 = 7, wd1 = 0x55 -> busy clears next cycle, R7 = 0x55, any_busy = 0.
- Mark/clear race: busy[9] set, then same cycle mark_a = 9 and we1 with wa1 = 9 -> R9 updated, busy[9] remains 1.
- LED tap: we0, wa0 = 4, wd0 = 0xF3 -> led = 4'h3 after the edge; a write to R5 leaves led unchanged.
